// File: rtl/spi_cmd_regfile.sv
// SPI mode-0 slave: command byte (rw + 7-bit addr) followed by auto-incrementing data bytes into a register bank.
// Optional sck-stall abort is compiled in with `define SPICMD_TIMEOUT_EN.
module spi_cmd_regfile #(
    parameter int         NUM_REGS    = 8,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] ID_VALUE    = 8'hD4,
    parameter logic [7:0] REG_RST     = 8'h00,
    parameter int         TIMEOUT_CYC = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ncs,
    input  logic                    sck,
    input  logic                    mosi,
    output logic                    miso,
    output logic [NUM_REGS*8-1:0]   reg_q,
    output logic [NUM_REGS-1:0]     wr_strobe,
    output logic                    frame_done,
    output logic                    cmd_err
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT_NCS} state_t;

    localparam logic [6:0] LAST_ADDR = 7'(NUM_REGS - 1);
    localparam logic [6:0] NREGS_A   = 7'(NUM_REGS);
    localparam logic [6:0] ID_ADDR   = 7'h7F;

    logic [SYNC_STAGES-1:0] ncs_sync_q, sck_sync_q, mosi_sync_q;
    logic                   sck_prev_q;
    logic                   ncs_s, sck_s, mosi_s, sck_rise, sck_fall;

    state_t      state_q;
    logic [2:0]  bit_cnt_q;
    logic [6:0]  rx_q;
    logic [7:0]  tx_q;
    logic        rw_q;
    logic [6:0]  addr_q;
    logic        cmd_done_q;
    logic        armed_q;
    logic        miso_q, frame_done_q, cmd_err_q;

    logic [7:0]  rx_next;
    logic [6:0]  addr_inc;
    logic        nb_rw;
    logic [6:0]  nb_addr;
    logic [7:0]  rd_val, next_byte;
    logic        wr_en;
    logic        timeout;
    logic [7:0]  regs_rd [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncs_sync_q  <= '0;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
        end else begin
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sck_prev_q  <= sck_s;
        end
    end

    assign ncs_s    = ncs_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign rx_next  = {rx_q, mosi_s};

    // Reserved and unimplemented addresses hold still; the last implemented one wraps.
    always_comb begin
        addr_inc = addr_q;
        if (addr_q == LAST_ADDR)
            addr_inc = 7'd0;
        else if (addr_q < NREGS_A)
            addr_inc = addr_q + 7'd1;
    end

    always_comb begin
        nb_rw   = (state_q == CMD) ? rx_next[7]   : rw_q;
        nb_addr = (state_q == CMD) ? rx_next[6:0] : addr_inc;
        rd_val  = 8'hFF;
        for (int i = 0; i < NUM_REGS; i++)
            if (nb_addr == 7'(i))
                rd_val = regs_rd[i];
        next_byte = 8'h00;
        if (nb_rw)
            next_byte = (nb_addr == ID_ADDR) ? ID_VALUE : rd_val;
    end

    assign wr_en = (state_q == DATA) && !ncs_s && sck_rise && (bit_cnt_q == 3'd7)
                   && !rw_q && (addr_q < NREGS_A);

`ifdef SPICMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            to_active;

    assign to_active = ((state_q == CMD) || (state_q == DATA)) && !ncs_s && !sck_rise && !sck_fall;
    assign timeout   = to_active && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt_q <= '0;
        else if (to_active && !timeout)
            to_cnt_q <= to_cnt_q + TO_W'(1);
        else
            to_cnt_q <= '0;
    end
`else
    wire unused_timeout_cyc = (TIMEOUT_CYC == 0);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            rx_q         <= 7'd0;
            tx_q         <= 8'd0;
            rw_q         <= 1'b0;
            addr_q       <= 7'd0;
            cmd_done_q   <= 1'b0;
            armed_q      <= 1'b0;
            miso_q       <= 1'b0;
            frame_done_q <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            cmd_err_q    <= 1'b0;
            // After a reset we only accept a frame once ncs has been seen high.
            if (ncs_s)
                armed_q <= 1'b1;
            if (state_q != IDLE && ncs_s) begin
                state_q      <= IDLE;
                frame_done_q <= cmd_done_q;
                cmd_done_q   <= 1'b0;
                miso_q       <= 1'b0;
                bit_cnt_q    <= 3'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!ncs_s && armed_q) begin
                            state_q    <= CMD;
                            bit_cnt_q  <= 3'd0;
                            tx_q       <= 8'd0;
                            miso_q     <= 1'b0;
                            cmd_done_q <= 1'b0;
                        end
                    end
                    CMD, DATA: begin
                        if (timeout) begin
                            state_q    <= WAIT_NCS;
                            cmd_err_q  <= 1'b1;
                            cmd_done_q <= 1'b0;
                            miso_q     <= 1'b0;
                            tx_q       <= 8'd0;
                            bit_cnt_q  <= 3'd0;
                        end else if (sck_rise) begin
                            rx_q      <= rx_next[6:0];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                tx_q <= next_byte;
                                if (state_q == CMD) begin
                                    state_q    <= DATA;
                                    rw_q       <= rx_next[7];
                                    addr_q     <= rx_next[6:0];
                                    cmd_done_q <= 1'b1;
                                    if (rx_next[6:0] >= NREGS_A && rx_next[6:0] != ID_ADDR)
                                        cmd_err_q <= 1'b1;
                                end else begin
                                    addr_q <= addr_inc;
                                end
                            end
                        end else if (sck_fall) begin
                            miso_q <= tx_q[7];
                            tx_q   <= {tx_q[6:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [7:0] r_q;
            logic       st_q;
            logic       hit;

            assign hit = wr_en && (addr_q == 7'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q  <= REG_RST;
                    st_q <= 1'b0;
                end else begin
                    st_q <= hit;
                    if (hit)
                        r_q <= rx_next;
                end
            end

            assign regs_rd[gi]      = r_q;
            assign reg_q[8*gi +: 8] = r_q;
            assign wr_strobe[gi]    = st_q;
        end
    endgenerate

    assign miso       = miso_q;
    assign frame_done = frame_done_q;
    assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_spi_cmd_regfile.sv
// Directed bench for spi_cmd_regfile: table of full frames plus hand-written abort/reset/timeout sequences.
module tb_spi_cmd_regfile;

    localparam int NR = 8;

    logic          clk, rst_n, ncs, sck, mosi;
    logic          miso, frame_done, cmd_err;
    logic [NR*8-1:0] reg_q;
    logic [NR-1:0] wr_strobe;

    spi_cmd_regfile #(
        .NUM_REGS(NR), .SYNC_STAGES(2), .ID_VALUE(8'hD4), .REG_RST(8'h00), .TIMEOUT_CYC(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ncs(ncs), .sck(sck), .mosi(mosi), .miso(miso),
        .reg_q(reg_q), .wr_strobe(wr_strobe), .frame_done(frame_done), .cmd_err(cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int fd_cnt = 0;
    int err_cnt = 0;
    int strb_cnt [NR];
    initial for (int i = 0; i < NR; i++) strb_cnt[i] = 0;

    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (cmd_err) err_cnt++;
        for (int i = 0; i < NR; i++)
            if (wr_strobe[i]) strb_cnt[i]++;
    end

    int fd0, err0;
    int strb0 [NR];

    typedef struct {
        logic [23:0] tx;
        int          n;
        logic [23:0] exp_rx;
        int          exp_fd;
        int          exp_err;
        logic [7:0]  exp_strb;
        logic [63:0] exp_regs;
    } vec_t;
    vec_t vecs [$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    task automatic snap();
        fd0 = fd_cnt;
        err0 = err_cnt;
        for (int i = 0; i < NR; i++) strb0[i] = strb_cnt[i];
    endtask

    task automatic check_counts(input string name, input int efd, input int eerr, input logic [7:0] estrb);
        logic [7:0] mask;
        int tot;
        mask = '0;
        tot = 0;
        for (int i = 0; i < NR; i++) begin
            if (strb_cnt[i] - strb0[i] == 1) mask[i] = 1'b1;
            tot += strb_cnt[i] - strb0[i];
        end
        check({name, "_frame_done"}, 64'(fd_cnt - fd0), 64'(efd));
        check({name, "_cmd_err"}, 64'(err_cnt - err0), 64'(eerr));
        check({name, "_strobe_mask"}, 64'(mask), 64'(estrb));
        check({name, "_strobe_total"}, 64'(tot), 64'($countones(estrb)));
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = tx[i];
            #80;
            rx[i] = miso;
            sck = 1'b1;
            #80;
            sck = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [23:0] tx, input int n, output logic [23:0] rx);
        logic [7:0] b;
        rx = '0;
        ncs = 1'b0;
        #200;
        for (int k = 0; k < n; k++) begin
            spi_bits(tx[23-8*k -: 8], 8, b);
            rx[23-8*k -: 8] = b;
        end
        #200;
        ncs = 1'b1;
        #300;
    endtask

    task automatic add_vec(input logic [23:0] tx, input int n, input logic [23:0] rx, input int fd,
                           input int err, input logic [7:0] strb, input logic [63:0] regs);
        vec_t v;
        v.tx = tx; v.n = n; v.exp_rx = rx; v.exp_fd = fd; v.exp_err = err;
        v.exp_strb = strb; v.exp_regs = regs;
        vecs.push_back(v);
    endtask

    initial begin
        logic [23:0] rx;
        logic [7:0]  b;
        logic [23:0] erx;
        string       nm;

        rst_n = 1'b0; ncs = 1'b1; sck = 1'b0; mosi = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("reset_ctl", 64'({miso, frame_done, cmd_err, wr_strobe}), 64'd0);
        check("reset_regs", reg_q, 64'd0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        //       tx         n  expected miso  fd err strobes  reg_q after frame
        add_vec(24'h021122, 3, 24'h000000, 1, 0, 8'h0C, 64'h00000000_22110000);
        add_vec(24'h07ABCD, 3, 24'h000000, 1, 0, 8'h81, 64'hAB000000_221100CD);
        add_vec(24'h870000, 3, 24'h00ABCD, 1, 0, 8'h00, 64'hAB000000_221100CD);
        add_vec(24'hFF0000, 3, 24'h00D4D4, 1, 0, 8'h00, 64'hAB000000_221100CD);
        add_vec(24'h900000, 2, 24'h00FF00, 1, 1, 8'h00, 64'hAB000000_221100CD);
        add_vec(24'h105500, 2, 24'h000000, 1, 1, 8'h00, 64'hAB000000_221100CD);
        add_vec(24'h820000, 3, 24'h001122, 1, 0, 8'h00, 64'hAB000000_221100CD);
        add_vec(24'h7F9900, 2, 24'h000000, 1, 0, 8'h00, 64'hAB000000_221100CD);

        foreach (vecs[v]) begin
            snap();
            run_frame(vecs[v].tx, vecs[v].n, rx);
            erx = vecs[v].exp_rx;
            for (int k = 0; k < vecs[v].n; k++) begin
                nm = $sformatf("v%0d_miso%0d", v, k);
                check(nm, 64'(rx[23-8*k -: 8]), 64'(erx[23-8*k -: 8]));
            end
            check_counts($sformatf("v%0d", v), vecs[v].exp_fd, vecs[v].exp_err, vecs[v].exp_strb);
            check($sformatf("v%0d_regs", v), reg_q, vecs[v].exp_regs);
        end

        // Partial data byte then ncs high: byte dropped, frame still counted.
        snap();
        ncs = 1'b0;
        #200;
        spi_bits(8'h01, 8, b);
        spi_bits(8'hF0, 4, b);
        #200;
        ncs = 1'b1;
        #300;
        check_counts("abort", 1, 0, 8'h00);
        check("abort_regs", reg_q, 64'hAB000000_221100CD);

        // Reset in the middle of a command byte, frame continues afterwards.
        snap();
        ncs = 1'b0;
        #200;
        spi_bits(8'h03, 4, b);
        rst_n = 1'b0;
        #1;
        check("midrst_ctl", 64'({miso, frame_done, cmd_err, wr_strobe}), 64'd0);
        check("midrst_regs", reg_q, 64'd0);
        #50;
        rst_n = 1'b1;
        #100;
        spi_bits(8'h03, 8, b);
        spi_bits(8'h77, 8, b);
        #200;
        ncs = 1'b1;
        #300;
        check_counts("midrst_tail", 0, 0, 8'h00);
        check("midrst_tail_regs", reg_q, 64'd0);

        snap();
        run_frame(24'h055A00, 2, rx);
        check_counts("post_rst", 1, 0, 8'h20);
        check("post_rst_regs", reg_q, 64'h00005A00_00000000);

`ifdef SPICMD_TIMEOUT_EN
        snap();
        ncs = 1'b0;
        #200;
        spi_bits(8'h01, 8, b);
        repeat (100) @(posedge clk);
        #1;
        check("timeout_err", 64'(err_cnt - err0), 64'd1);
        spi_bits(8'h42, 8, b);
        #200;
        ncs = 1'b1;
        #300;
        check_counts("timeout", 0, 1, 8'h00);
        check("timeout_regs", reg_q, 64'h00005A00_00000000);
        check("timeout_miso", 64'(miso), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
